// File: rtl/p_encoder_pkg.sv
// ---------------------------------------------------------------------------
// p_encoder_pkg
//   Shared constants and helpers for the p_encoder priority encoder.
//   - DEFAULT_WIDTH / DEFAULT_IDX_W : default request width and index width
//   - clog2_safe(n)                 : ceil(log2(n)), never less than 1, so a
//                                     2-request encoder still gets a 1-bit index
// ---------------------------------------------------------------------------
package p_encoder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_IDX_W = 3;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : p_encoder_pkg

// File: rtl/p_encoder_core.sv
// ---------------------------------------------------------------------------
// p_encoder_core
//   Purely combinational priority scan over a request vector.
//   Ports:
//     a_i      [WIDTH-1:0]  request vector
//     idx_o    [IDX_W-1:0]  index of the winning bit (0 when nothing is set)
//     any_o                 1 when at least one request bit is set
//     onehot_o [WIDTH-1:0]  one-hot vector with only the winning bit set
//   MSB_FIRST = 1 : highest-numbered set bit wins
//   MSB_FIRST = 0 : lowest-numbered set bit wins
// ---------------------------------------------------------------------------
module p_encoder_core
  import p_encoder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int IDX_W     = clog2_safe(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic [WIDTH-1:0] onehot_o
);

  // The scan visits bits from lowest to highest priority, so the last set
  // bit seen is the winner. Each bit is tested with an explicit if, so an
  // X/Z bit is treated as "not set" rather than relying on a full-case
  // decode. Only indices 0..WIDTH-1 can ever be written, so unused codes of
  // a non-power-of-two width are never produced.
  always_comb begin
    int j;
    idx_o    = '0;
    any_o    = 1'b0;
    onehot_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      j = MSB_FIRST ? i : (WIDTH - 1 - i);
      if (a_i[j] == 1'b1) begin
        idx_o       = IDX_W'(j);
        any_o       = 1'b1;
        onehot_o    = '0;
        onehot_o[j] = 1'b1;
      end
    end
  end

endmodule : p_encoder_core

// File: rtl/p_encoder.sv
// ---------------------------------------------------------------------------
// p_encoder
//   Priority encoder with a single registered output stage (latency 1).
//   There is no handshake and no enable: a new result is registered every
//   clock from the request vector sampled on that edge.
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous active-high reset; clears all outputs, wins over a
//     a      [WIDTH-1:0] request vector
//     out    [IDX_W-1:0] registered winning index (qualify with valid)
//     valid  registered: sampled a had at least one bit set
//     grant  [WIDTH-1:0] registered one-hot of the winning bit
// ---------------------------------------------------------------------------
module p_encoder
  import p_encoder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int IDX_W     = clog2_safe(WIDTH),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  output logic [WIDTH-1:0] grant
);

  logic [IDX_W-1:0] out_d,   out_q;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] grant_d, grant_q;

  p_encoder_core #(
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .a_i      (a),
    .idx_o    (out_d),
    .any_o    (valid_d),
    .onehot_o (grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign grant = grant_q;

endmodule : p_encoder

// File: tb/tb_p_encoder.sv
// ---------------------------------------------------------------------------
// tb_p_encoder
//   Directed bench for p_encoder. Three instances share clock and reset:
//     u_msb : WIDTH=8, MSB_FIRST=1 (default configuration)
//     u_lsb : WIDTH=8, MSB_FIRST=0
//     u_w5  : WIDTH=5, MSB_FIRST=1 (non-power-of-two width)
//   Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
//   the following rising edge.
// ---------------------------------------------------------------------------
module tb_p_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_m, grant_m;
  logic [2:0] out_m;
  logic       valid_m;

  logic [7:0] a_l, grant_l;
  logic [2:0] out_l;
  logic       valid_l;

  logic [4:0] a_5, grant_5;
  logic [2:0] out_5;
  logic       valid_5;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard for the random sweep: {valid, grant, out}
  logic [11:0] exp_q[$];

  p_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .a(a_m), .out(out_m), .valid(valid_m), .grant(grant_m)
  );

  p_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .a(a_l), .out(out_l), .valid(valid_l), .grant(grant_l)
  );

  p_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_w5 (
    .clk(clk), .rst(rst), .a(a_5), .out(out_5), .valid(valid_5), .grant(grant_5)
  );

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: highest set bit, scanned from the top down
  function automatic logic [11:0] model_msb(input logic [7:0] v);
    logic [11:0] r;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) begin
        r = {1'b1, 8'(8'd1 << k), 3'(k)};
        break;
      end
    end
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; a_m = 8'hFF; a_l = 8'hFF; a_5 = 5'h1F;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++;
      if ({valid_m, grant_m, out_m} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_msb cyc%0d got v=%0b g=%h o=%0d want 0/00/0", c, valid_m, grant_m, out_m);
      end
      n_vec++;
      if ({valid_l, grant_l, out_l} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_lsb cyc%0d got v=%0b g=%h o=%0d want 0/00/0", c, valid_l, grant_l, out_l);
      end
      n_vec++;
      if ({valid_5, grant_5, out_5} !== 9'h000) begin
        n_err++;
        $display("FAIL reset_w5 cyc%0d got v=%0b g=%h o=%0d want 0/00/0", c, valid_5, grant_5, out_5);
      end
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (out_m !== 3'd7 || valid_m !== 1'b1 || grant_m !== 8'h80) begin
      n_err++;
      $display("FAIL release_msb got o=%0d v=%0b g=%h want 7/1/80", out_m, valid_m, grant_m);
    end
    n_vec++;
    if (out_l !== 3'd0 || valid_l !== 1'b1 || grant_l !== 8'h01) begin
      n_err++;
      $display("FAIL allones_lsb got o=%0d v=%0b g=%h want 0/1/01", out_l, valid_l, grant_l);
    end
    n_vec++;
    if (out_5 !== 3'd4 || valid_5 !== 1'b1 || grant_5 !== 5'h10) begin
      n_err++;
      $display("FAIL allones_w5 got o=%0d v=%0b g=%h want 4/1/10", out_5, valid_5, grant_5);
    end
  endtask

  task automatic test_mixed();
    a_m = 8'b0010_0100;
    step();
    n_vec++;
    if (out_m !== 3'd5 || valid_m !== 1'b1 || grant_m !== 8'b0010_0000) begin
      n_err++;
      $display("FAIL mixed_24 got o=%0d v=%0b g=%h want 5/1/20", out_m, valid_m, grant_m);
    end
    a_m = 8'b1000_0001;
    step();
    n_vec++;
    if (out_m !== 3'd7 || valid_m !== 1'b1 || grant_m !== 8'h80) begin
      n_err++;
      $display("FAIL mixed_81 got o=%0d v=%0b g=%h want 7/1/80", out_m, valid_m, grant_m);
    end
  endtask

  task automatic test_walking_one();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 8'd1 << k;
      a_m = v;
      step();
      n_vec++;
      if (out_m !== 3'(k) || valid_m !== 1'b1 || grant_m !== v) begin
        n_err++;
        $display("FAIL walk_%0d got o=%0d v=%0b g=%h want %0d/1/%h", k, out_m, valid_m, grant_m, k, v);
      end
    end
  endtask

  task automatic test_zero();
    a_m = 8'h00;
    step();
    n_vec++;
    if (out_m !== 3'd0 || valid_m !== 1'b0 || grant_m !== 8'h00) begin
      n_err++;
      $display("FAIL zero got o=%0d v=%0b g=%h want 0/0/00", out_m, valid_m, grant_m);
    end
    a_m = 8'h01;
    step();
    n_vec++;
    if (out_m !== 3'd0 || valid_m !== 1'b1 || grant_m !== 8'h01) begin
      n_err++;
      $display("FAIL bit0 got o=%0d v=%0b g=%h want 0/1/01", out_m, valid_m, grant_m);
    end
  endtask

  task automatic test_lsb_priority();
    a_l = 8'b0110_1000;
    step();
    n_vec++;
    if (out_l !== 3'd3 || valid_l !== 1'b1 || grant_l !== 8'b0000_1000) begin
      n_err++;
      $display("FAIL lsb_68 got o=%0d v=%0b g=%h want 3/1/08", out_l, valid_l, grant_l);
    end
    a_l = 8'hFF;
    step();
    n_vec++;
    if (out_l !== 3'd0 || valid_l !== 1'b1 || grant_l !== 8'h01) begin
      n_err++;
      $display("FAIL lsb_ff got o=%0d v=%0b g=%h want 0/1/01", out_l, valid_l, grant_l);
    end
  endtask

  task automatic test_width5();
    a_5 = 5'b0_1010;
    step();
    n_vec++;
    if (out_5 !== 3'd3 || valid_5 !== 1'b1 || grant_5 !== 5'b0_1000) begin
      n_err++;
      $display("FAIL w5_0a got o=%0d v=%0b g=%h want 3/1/08", out_5, valid_5, grant_5);
    end
  endtask

  task automatic test_reset_sweep();
    logic [7:0]  v;
    logic [11:0] e;
    for (int c = 0; c < 8; c++) begin
      v = 8'($urandom_range(0, 255));
      a_m = v;
      rst = (c == 4);
      exp_q.push_back(rst ? 12'h000 : model_msb(v));
      step();
      e = exp_q.pop_front();
      n_vec++;
      if ({valid_m, grant_m, out_m} !== e) begin
        n_err++;
        $display("FAIL sweep_%0d a=%h rst=%0b got v=%0b g=%h o=%0d want v=%0b g=%h o=%0d",
                 c, v, rst, valid_m, grant_m, out_m, e[11], e[10:3], e[2:0]);
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    a_m = '0; a_l = '0; a_5 = '0;
    test_reset();
    test_mixed();
    test_walking_one();
    test_zero();
    test_lsb_priority();
    test_width5();
    test_reset_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_p_encoder
